// File: rtl/hpm_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : hpm_counter_bank
// Purpose  : Parametrised hardware performance-monitor counter bank. Each of
//            NumCounters counters selects one of NumEvents event lines and
//            adds that line's multi-bit increment every cycle. Adds per-counter
//            inhibit, sticky overflow flag with interrupt enable, and an
//            access-error flag for illegal CSR accesses.
// Revision : 1.0 - initial release
// ============================================================================
module hpm_counter_bank #(
  parameter int unsigned NumCounters = 6,
  parameter int unsigned CntWidth    = 64,
  parameter int unsigned NumEvents   = 32,
  parameter int unsigned EvtSelWidth = 5,
  parameter int unsigned IncWidth    = 2,
  parameter int unsigned DataWidth   = 64,
  localparam int unsigned IdxWidth   = (NumCounters > 1) ? $clog2(NumCounters) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          debug_mode_i,
  input  logic [IdxWidth-1:0]           idx_i,
  input  logic [1:0]                    type_i,
  input  logic                          re_i,
  input  logic                          we_i,
  input  logic [DataWidth-1:0]          wdata_i,
  output logic [DataWidth-1:0]          rdata_o,
  output logic                          err_o,
  input  logic [NumEvents*IncWidth-1:0] event_inc_i,
  output logic                          irq_o
);

  localparam int unsigned      NumSel     = 2 ** EvtSelWidth;
  localparam logic [1:0]       c_TYPE_LO  = 2'd0;
  localparam logic [1:0]       c_TYPE_HI  = 2'd1;
  localparam logic [1:0]       c_TYPE_EVT = 2'd2;
  localparam logic [1:0]       c_TYPE_RSV = 2'd3;
  localparam logic             c_WIDE     = (DataWidth == 64);
  localparam logic [IdxWidth:0] c_NUM_CNT = NumCounters[IdxWidth:0];

  // Write data zero-extended to 64 bits so every field slice is in range
  // for any legal DataWidth/CntWidth combination.
  logic [63:0]                        w_wdata64;
  logic                               w_bad;
  logic                               w_wr;
  logic [NumSel-1:0][IncWidth-1:0]    w_evt;
  logic [NumCounters-1:0][63:0]       w_rd_part;
  logic [NumCounters-1:0]             w_irq_src;
  logic [63:0]                        w_rd64;
  logic                               w_unused_evt0;
  logic                               r_irq;

  assign w_wdata64 = 64'(wdata_i);

  // Event 0 is hard-wired "never", so its input bits are deliberately ignored.
  assign w_unused_evt0 = ^event_inc_i[IncWidth-1:0];

  // Event table padded to the full select range: index 0 and any select
  // beyond NumEvents read as zero increment, so the lookup is always in range.
  for (genvar e = 0; e < NumSel; e++) begin : g_evt
    if ((e > 0) && (e < NumEvents)) begin : g_live
      assign w_evt[e] = event_inc_i[e*IncWidth +: IncWidth];
    end else begin : g_never
      assign w_evt[e] = '0;
    end
  end

  // An access is illegal for out-of-range counters, the reserved type, and
  // the high half when the CSR is already wide enough to hold the counter.
  assign w_bad = ({1'b0, idx_i} >= c_NUM_CNT)
               | (type_i == c_TYPE_RSV)
               | ((type_i == c_TYPE_HI) & c_WIDE);
  assign err_o = (re_i | we_i) & w_bad;
  assign w_wr  = we_i & ~w_bad;

  for (genvar i = 0; i < NumCounters; i++) begin : g_cnt
    logic [CntWidth-1:0]    r_cnt;
    logic [EvtSelWidth-1:0] r_sel;
    logic                   r_of;
    logic                   r_ofie;
    logic                   r_inh;
    logic [CntWidth-1:0]    w_cnt_d;
    logic [EvtSelWidth-1:0] w_sel_d;
    logic                   w_of_d;
    logic                   w_ofie_d;
    logic                   w_inh_d;
    logic                   w_hit;
    logic                   w_sel_me;
    logic [IncWidth-1:0]    w_inc;
    logic [CntWidth:0]      w_sum;
    logic [63:0]            w_cnt64;
    logic [31:0]            w_evt_rd;
    logic [63:0]            w_val;

    assign w_sel_me = (idx_i == IdxWidth'(i));
    assign w_hit    = w_wr & w_sel_me;

    // Inhibit and debug freeze gate the increment; the sum keeps the carry.
    assign w_inc = (r_inh | debug_mode_i) ? '0 : w_evt[r_sel];
    assign w_sum = {1'b0, r_cnt} + (CntWidth+1)'(w_inc);

    // Next-state: count by default, a CNT write replaces this counter's
    // increment, an EVT write replaces the fields while counting continues.
    always_comb begin
      w_cnt_d  = w_sum[CntWidth-1:0];
      w_of_d   = r_of | w_sum[CntWidth];
      w_sel_d  = r_sel;
      w_ofie_d = r_ofie;
      w_inh_d  = r_inh;
      if (w_hit) begin
        case (type_i)
          c_TYPE_LO: begin
            if (c_WIDE) begin
              w_cnt_d = w_wdata64[CntWidth-1:0];
            end else begin
              w_cnt_d = {r_cnt[CntWidth-1:32], w_wdata64[31:0]};
            end
            w_of_d = r_of;
          end
          c_TYPE_HI: begin
            w_cnt_d = {w_wdata64[CntWidth-33:0], r_cnt[31:0]};
            w_of_d  = r_of;
          end
          c_TYPE_EVT: begin
            w_sel_d  = w_wdata64[EvtSelWidth-1:0];
            w_inh_d  = w_wdata64[29];
            w_ofie_d = w_wdata64[30];
            // A simultaneous overflow beats a software clear of the flag.
            w_of_d   = w_wdata64[31] | w_sum[CntWidth];
          end
          default: begin
          end
        endcase
      end
    end

    // Counter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt  <= '0;
        r_sel  <= '0;
        r_of   <= 1'b0;
        r_ofie <= 1'b0;
        r_inh  <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_d;
        r_sel  <= w_sel_d;
        r_of   <= w_of_d;
        r_ofie <= w_ofie_d;
        r_inh  <= w_inh_d;
      end
    end

    assign w_cnt64  = 64'(r_cnt);
    assign w_evt_rd = 32'(r_sel) | {r_of, r_ofie, r_inh, 29'd0};

    // Per-counter read view of the pre-update values for the requested type.
    always_comb begin
      w_val = '0;
      case (type_i)
        c_TYPE_LO:  w_val = w_cnt64;
        c_TYPE_HI:  w_val = w_cnt64 >> 32;
        c_TYPE_EVT: w_val = 64'(w_evt_rd);
        default:    w_val = '0;
      endcase
    end

    assign w_rd_part[i] = w_sel_me ? w_val : 64'd0;
    assign w_irq_src[i] = w_of_d & w_ofie_d;
  end

  // Only the addressed counter contributes a non-zero part, so OR them.
  always_comb begin
    w_rd64 = '0;
    for (int k = 0; k < NumCounters; k++) begin
      w_rd64 = w_rd64 | w_rd_part[k];
    end
  end

  // Truncation to DataWidth gives the low half for narrow CSRs.
  assign rdata_o = (re_i & ~w_bad) ? w_rd64[DataWidth-1:0] : '0;

  // Interrupt follows the next-state flags, so it rises one cycle after the
  // overflowing increment and drops one cycle after software clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |w_irq_src;
    end
  end

  assign irq_o = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_hpm_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpm_counter_bank
// Purpose  : Self-checking bench. Two instances share one stimulus stream:
//            A = 64-bit CSR / 64-bit counters / 32 events,
//            B = 32-bit CSR / 40-bit counters / 20 events.
//            A driver pushes expected responses from a reference model into a
//            queue; a monitor pops and compares on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hpm_counter_bank;

  localparam int NC = 6;

  typedef struct {
    bit [63:0] rd_a;
    bit        err_a;
    bit        irq_a;
    bit [31:0] rd_b;
    bit        err_b;
    bit        irq_b;
  } exp_t;

  logic        clk_i  = 1'b0;
  logic        rst_ni = 1'b0;
  logic        dbg    = 1'b0;
  logic [2:0]  idx    = '0;
  logic [1:0]  typ    = '0;
  logic        re     = 1'b0;
  logic        we     = 1'b0;
  logic [63:0] wdata  = '0;
  logic [63:0] ev     = '0;
  logic [63:0] rd_a;
  logic [31:0] rd_b;
  logic        err_a, err_b, irq_a, irq_b;

  logic [63:0] cur_ev  = '0;
  bit          cur_dbg = 1'b0;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state, indexed [instance][counter].
  bit [63:0] m_cnt  [2][NC];
  bit [4:0]  m_sel  [2][NC];
  bit        m_of   [2][NC];
  bit        m_ofie [2][NC];
  bit        m_inh  [2][NC];
  bit        m_irq  [2];
  int        p_cw   [2] = '{64, 40};
  int        p_dw   [2] = '{64, 32};
  int        p_ne   [2] = '{32, 20};

  always #5 clk_i = ~clk_i;

  hpm_counter_bank #(
    .NumCounters(6), .CntWidth(64), .NumEvents(32),
    .EvtSelWidth(5), .IncWidth(2), .DataWidth(64)
  ) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .debug_mode_i(dbg), .idx_i(idx),
    .type_i(typ), .re_i(re), .we_i(we), .wdata_i(wdata), .rdata_o(rd_a),
    .err_o(err_a), .event_inc_i(ev), .irq_o(irq_a)
  );

  hpm_counter_bank #(
    .NumCounters(6), .CntWidth(40), .NumEvents(20),
    .EvtSelWidth(5), .IncWidth(2), .DataWidth(32)
  ) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .debug_mode_i(dbg), .idx_i(idx),
    .type_i(typ), .re_i(re), .we_i(we), .wdata_i(wdata[31:0]), .rdata_o(rd_b),
    .err_o(err_b), .event_inc_i(ev[39:0]), .irq_o(irq_b)
  );

  function automatic bit m_err(int k);
    return (re || we) && ((int'(idx) >= NC) || (typ == 2'd3) ||
                          ((typ == 2'd1) && (p_dw[k] == 64)));
  endfunction

  function automatic bit [63:0] m_read(int k);
    bit [63:0] c;
    if (!re || m_err(k)) return 64'd0;
    c = m_cnt[k][idx];
    case (typ)
      2'd0:    return (p_dw[k] == 64) ? c : (c & 64'hFFFF_FFFF);
      2'd1:    return c >> 32;
      default: return {32'd0, m_of[k][idx], m_ofie[k][idx], m_inh[k][idx],
                       24'd0, m_sel[k][idx]};
    endcase
  endfunction

  task automatic model_reset(int k);
    for (int i = 0; i < NC; i++) begin
      m_cnt[k][i] = '0; m_sel[k][i] = '0;
      m_of[k][i] = 1'b0; m_ofie[k][i] = 1'b0; m_inh[k][i] = 1'b0;
    end
    m_irq[k] = 1'b0;
  endtask

  // Advance the model by one clock using the inputs held during that cycle.
  task automatic model_step(int k);
    bit [64:0] lim, s;
    bit [63:0] mask, inc;
    bit        wr, hit, carry, any;
    lim  = 65'd1 << p_cw[k];
    mask = 64'(lim - 65'd1);
    if (!rst_ni) begin
      model_reset(k);
      return;
    end
    wr  = we && !m_err(k);
    any = 1'b0;
    for (int i = 0; i < NC; i++) begin
      inc = 64'd0;
      if ((m_sel[k][i] != 5'd0) && (int'(m_sel[k][i]) < p_ne[k]) &&
          !m_inh[k][i] && !dbg)
        inc = (ev >> (2 * int'(m_sel[k][i]))) & 64'd3;
      s     = {1'b0, m_cnt[k][i]} + {1'b0, inc};
      carry = (s >= lim);
      hit   = wr && (int'(idx) == i);
      if (hit && typ == 2'd0) begin
        if (p_dw[k] == 64) m_cnt[k][i] = wdata & mask;
        else m_cnt[k][i] = (m_cnt[k][i] & ~64'hFFFF_FFFF) | {32'd0, wdata[31:0]};
      end else if (hit && typ == 2'd1) begin
        m_cnt[k][i] = {wdata[31:0], m_cnt[k][i][31:0]} & mask;
      end else begin
        m_cnt[k][i] = 64'(s % lim);
        if (hit && typ == 2'd2) begin
          m_sel[k][i]  = wdata[4:0];
          m_inh[k][i]  = wdata[29];
          m_ofie[k][i] = wdata[30];
          m_of[k][i]   = wdata[31] | carry;
        end else begin
          m_of[k][i] = m_of[k][i] | carry;
        end
      end
      any = any | (m_of[k][i] & m_ofie[k][i]);
    end
    m_irq[k] = any;
  endtask

  // One clock cycle of stimulus; called right after a rising edge.
  task automatic cyc(input bit r, input bit [2:0] i, input bit [1:0] t,
                     input bit rr, input bit ww, input bit [63:0] wd);
    exp_t      x;
    bit [63:0] tmp;
    #1;
    rst_ni = r; idx = i; typ = t; re = rr; we = ww; wdata = wd;
    ev = cur_ev; dbg = cur_dbg;
    if (!r) begin
      model_reset(0);
      model_reset(1);
    end
    x.rd_a  = m_read(0);
    x.err_a = m_err(0);
    x.irq_a = m_irq[0];
    tmp     = m_read(1);
    x.rd_b  = tmp[31:0];
    x.err_b = m_err(1);
    x.irq_b = m_irq[1];
    q.push_back(x);
    @(posedge clk_i);
    model_step(0);
    model_step(1);
  endtask

  task automatic rd(input bit [2:0] i, input bit [1:0] t);
    cyc(1'b1, i, t, 1'b1, 1'b0, 64'd0);
  endtask

  task automatic wr(input bit [2:0] i, input bit [1:0] t, input bit [63:0] d);
    cyc(1'b1, i, t, 1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents its combinational response mid-cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk_i);
      if (q.size() > 0) begin
        x = q.pop_front();
        check("rdata_a", rd_a, x.rd_a);
        check("err_a", 64'(err_a), 64'(x.err_a));
        check("irq_a", 64'(irq_a), 64'(x.irq_a));
        check("rdata_b", 64'(rd_b), 64'(x.rd_b));
        check("err_b", 64'(err_b), 64'(x.err_b));
        check("irq_b", 64'(irq_b), 64'(x.irq_b));
      end
    end
  end

  initial begin
    bit [2:0]  ri;
    bit [1:0]  rt;
    bit [63:0] wd;
    model_reset(0);
    model_reset(1);
    @(posedge clk_i);

    // Reset and read-back of every index/type, including illegal ones.
    cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 64'd0);
    cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 8; i++)
      for (int t = 0; t < 4; t++) rd(3'(i), 2'(t));

    // Counter 0 on event 5 incrementing by 3 for four cycles.
    wr(3'd0, 2'd2, 64'd5);
    cur_ev = 64'd3 << 10;
    idle(4);
    cur_ev = '0;
    rd(3'd0, 2'd0); rd(3'd3, 2'd0); rd(3'd5, 2'd0);

    // Overflow on counter 1 with interrupt enabled, then software clear.
    wr(3'd1, 2'd2, (64'd1 << 30) | 64'd7);
    wr(3'd1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFE);
    wr(3'd1, 2'd1, 64'hFF);
    cur_ev = 64'd3 << 14;
    idle(1);
    cur_ev = '0;
    idle(2);
    rd(3'd1, 2'd0); rd(3'd1, 2'd1); rd(3'd1, 2'd2);
    wr(3'd1, 2'd2, (64'd1 << 30) | 64'd7);
    idle(2);
    rd(3'd1, 2'd2);

    // Overflow coinciding with an EVT write that clears the flag.
    wr(3'd1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(3'd1, 2'd1, 64'hFF);
    cur_ev = 64'd1 << 14;
    wr(3'd1, 2'd2, (64'd1 << 30) | 64'd7);
    cur_ev = '0;
    idle(2);
    rd(3'd1, 2'd2);
    wr(3'd1, 2'd2, 64'd7);
    idle(2);

    // Counter write overrides that counter's increment only.
    wr(3'd2, 2'd2, 64'd5);
    cur_ev = 64'd1 << 10;
    wr(3'd2, 2'd0, 64'd100);
    cur_ev = '0;
    rd(3'd2, 2'd0); rd(3'd0, 2'd0);

    // Debug freeze and inhibit, then resume.
    cur_ev = '1;
    cur_dbg = 1'b1;
    idle(10);
    rd(3'd0, 2'd0);
    cur_dbg = 1'b0;
    idle(1);
    rd(3'd0, 2'd0);
    wr(3'd0, 2'd2, (64'd1 << 29) | 64'd5);
    idle(10);
    rd(3'd0, 2'd0);
    wr(3'd0, 2'd2, 64'd5);
    idle(1);
    rd(3'd0, 2'd0);
    cur_ev = '0;

    // High/low halves on the narrow CSR; HI access is illegal on the wide one.
    wr(3'd3, 2'd2, 64'd9);
    wr(3'd3, 2'd1, 64'd1);
    wr(3'd3, 2'd0, 64'hFFFF_FFFF);
    cur_ev = 64'd1 << 18;
    idle(1);
    cur_ev = '0;
    rd(3'd3, 2'd1); rd(3'd3, 2'd0);

    // Select beyond the narrow instance's event count never increments it.
    wr(3'd4, 2'd2, 64'd25);
    cur_ev = '1;
    idle(3);
    cur_ev = '0;
    rd(3'd4, 2'd0);

    // Randomized traffic with one mid-run reset carrying a pending write.
    for (int n = 0; n < 2000; n++) begin
      cur_ev  = {$urandom, $urandom};
      cur_dbg = ($urandom_range(0, 15) == 0);
      ri = 3'($urandom_range(0, 7));
      rt = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       wd = {$urandom, $urandom};
        1:       wd = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 6));
        2:       wd = 64'($urandom_range(0, 1000));
        default: wd = {32'd0, $urandom} & 64'hE000_001F;
      endcase
      if (n == 1000)
        cyc(1'b0, ri, 2'd0, 1'b0, 1'b1, wd);
      else
        cyc(1'b1, ri, rt, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), wd);
    end
    cur_ev = '0;
    cur_dbg = 1'b0;
    for (int i = 0; i < NC; i++) begin
      rd(3'(i), 2'd0); rd(3'(i), 2'd1); rd(3'(i), 2'd2);
    end

    @(negedge clk_i);
    @(negedge clk_i);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
